mem_system_param: RTL and testbench
===================================

Name: mem_system_param

Overview:
- Parametrised direct-mapped, write-back, write-allocate cache controller with an integrated tag/data array.
- Next generation of the data-memory system: line size, index depth and address width are parameters, and the backing memory sits behind an external pipelined request/response port instead of a fixed banked instance.
- Sits between the processor memory stage (or fetch) and main memory; keeps the Rd/Wr/Done/Stall/CacheHit/err front-end contract.

Parameters:
- ADDR_W, 16, byte-address width.
- INDEX_W, 8, index bits; 2^INDEX_W lines.
- OFFSET_W, 2, word-offset bits; 2^OFFSET_W 16-bit words per line.
- MEM_TYPE, 1, 1 = data memory, 0 = instruction memory. When 0, any Wr request is an err.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Addr  in  ADDR_W  byte address; bit 0 must be 0.
- DataIn  in  16  write data.
- Rd  in  1  read request.
- Wr  in  1  write request.
- DataOut  out  16  read data, valid while Done=1.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  busy; requests are ignored while high.
- CacheHit  out  1  qualified by Done: 1 = hit, 0 = serviced by a miss.
- err  out  1  one-cycle error pulse.
- mem_addr  out  ADDR_W  word-aligned memory address.
- mem_wdata  out  16  memory write data.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- mem_busy  in  1  memory cannot accept a request this cycle.
- mem_rdata  in  16  memory read data.
- mem_rvalid  in  1  mem_rdata valid; returns are in order.

Behaviour:
- Address split: tag = Addr[ADDR_W-1 : INDEX_W+OFFSET_W+1], index = next INDEX_W bits, word = Addr[OFFSET_W:1].
- Reset (rst=0, async): all valid and dirty bits cleared; FSM to IDLE.
  - Outputs: Done=0, Stall=0, CacheHit=0, err=0, DataOut=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - Data and tag arrays are not cleared.
- FSM states: IDLE, COMPARE, WB, ALLOC, FILL, DONE.
- IDLE: accepts a request when exactly one of Rd/Wr is high.
  - Latches Addr/DataIn/op; goes to COMPARE; Stall=1 from the next cycle.
  - Error cases: Rd&Wr, Addr[0]=1, or Wr with MEM_TYPE=0 → err pulses the next cycle, no state change, Stall stays 0.
- COMPARE, hit (valid & tag match):
  - Read drives DataOut; write updates the word and sets dirty.
  - Done=1 and CacheHit=1 this cycle; back to IDLE.
  - Hit latency: request cycle + 1.
- COMPARE, miss: go to WB if the victim is valid and dirty, else ALLOC.
- WB: issues 2^OFFSET_W writes of the victim line, word 0 first.
  - mem_addr built from {victim tag, index, word, 1'b0}.
  - One write per cycle when mem_busy=0; with mem_busy=1 the request is held stable and retried.
  - After the last write → ALLOC.
- ALLOC: issues 2^OFFSET_W reads of the new line under the same busy rule, then → FILL.
- FILL: counts mem_rvalid beats into words 0..N-1.
  - mem_rvalid is accepted during ALLOC as well.
  - After the last beat: tag written, valid=1, dirty=0 → DONE.
- DONE: performs the latched op on the filled line (write merges DataIn and sets dirty).
  - Done=1, CacheHit=0; → IDLE.
- Stall=1 in COMPARE on a miss and in WB, ALLOC, FILL, DONE; 0 in IDLE.
- Combinational ports:
  - mem_rd/mem_wr are never both 1.
  - Outputs are only asserted in the matching state and only when mem_busy=0.
  - mem_rdata is ignored in IDLE.
- Reset mid-miss: any in-flight memory responses after reset are ignored; the request is lost (no Done).
- Done and err never assert in the same cycle.

Optional Feature:
- Macro: MEM_SYSTEM_STATS_EN.
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - Each increments on a Done with CacheHit=1 / 0 respectively.
  - Saturate at 16'hFFFF; cleared by rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. After reset, Rd Addr=16'h0010 → WB skipped; 4 mem_rd to 0x0010,0x0012,0x0014,0x0016; Done with CacheHit=0 and DataOut = word0 returned.
2. Wr Addr=0x0012 DataIn=0xBEEF, then Rd 0x0012 → both complete one cycle after request with CacheHit=1; DataOut=0xBEEF.
3. Rd Addr=0x0810 (same index 0x02 for defaults, different tag) → 4 mem_wr 0x0010–0x0016 with word1=0xBEEF, then 4 mem_rd 0x0810–0x0816; CacheHit=0.
4. Rd=1 and Wr=1 together, or Addr=0x0013 → err=1 for one cycle; Stall=0; no mem_rd/mem_wr.
5. mem_busy=1 for 3 cycles during ALLOC → mem_rd and mem_addr held stable; the miss completes 3 cycles later than with mem_busy=0.
6. rst pulled low during FILL → all outputs 0 immediately; the next Rd to the same address misses.

Source files
------------

// File: rtl/mem_system_param.sv
// rtl/mem_system_param.sv - parametrised direct-mapped write-back cache with pipelined memory port
//
// Direct-mapped, write-back, write-allocate cache controller with integrated
// tag/data arrays. Misses write back a dirty victim line and then refill the
// line from an external pipelined memory port with in-order read returns.
//
// Optional build macro: MEM_SYSTEM_STATS_EN adds the hit_cnt/miss_cnt outputs.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   Addr        byte address (bit 0 must be 0)
//   DataIn      write data
//   Rd / Wr     read / write request (exactly one at a time)
//   DataOut     read data, valid while Done=1
//   Done        one-cycle completion pulse
//   Stall       busy; requests are ignored while high
//   CacheHit    qualified by Done: 1 = hit, 0 = serviced by a miss
//   err         one-cycle error pulse for a malformed request
//   mem_addr    word-aligned memory address
//   mem_wdata   memory write data
//   mem_rd      memory read request
//   mem_wr      memory write request
//   mem_busy    memory cannot accept a request this cycle
//   mem_rdata   memory read data
//   mem_rvalid  mem_rdata valid (in-order returns)
//   hit_cnt     (MEM_SYSTEM_STATS_EN) saturating hit counter
//   miss_cnt    (MEM_SYSTEM_STATS_EN) saturating miss counter

module mem_system_param #(
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 2,
  parameter bit MEM_TYPE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [15:0]       DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [15:0]       DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_busy,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid
`ifdef MEM_SYSTEM_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 1;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam logic [OFFSET_W:0] BEATS_ALL  = (OFFSET_W+1)'(WORDS);
  localparam logic [OFFSET_W:0] BEATS_LAST = (OFFSET_W+1)'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WB,
    S_ALLOC,
    S_FILL,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Storage: data/tag arrays are never reset, only the per-line state bits.
  logic [15:0]      data_arr [LINES*WORDS];
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  // Latched request
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_word;
  logic [15:0]         req_data;
  logic                req_wr;

  // Burst counters: writes issued, reads issued, read beats received.
  // beat_cnt is one bit wider so "all beats in" is distinguishable from
  // "waiting for the last beat" when returns finish during ALLOC.
  logic [OFFSET_W-1:0] wb_cnt;
  logic [OFFSET_W-1:0] rd_cnt;
  logic [OFFSET_W:0]   beat_cnt;

  logic err_q;

  // Incoming request decode
  logic [TAG_W-1:0]    in_tag;
  logic [INDEX_W-1:0]  in_idx;
  logic [OFFSET_W-1:0] in_word;
  logic                req_ok;
  logic                req_bad;

  assign in_tag  = Addr[ADDR_W-1 -: TAG_W];
  assign in_idx  = Addr[OFFSET_W+1 +: INDEX_W];
  assign in_word = Addr[1 +: OFFSET_W];

  assign req_ok  = (Rd ^ Wr) && !Addr[0] && !(Wr && !MEM_TYPE);
  assign req_bad = (Rd || Wr) && !req_ok;

  // Lookup against the latched request
  logic        hit;
  logic        victim_dirty;
  logic [15:0] rd_word;
  logic        beat_take;
  logic        fill_last;
  logic        word_write;

  assign hit          = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign rd_word      = data_arr[{req_idx, req_word}];

  // Read beats may already arrive while later reads are still being issued.
  assign beat_take = mem_rvalid && ((state == S_ALLOC) || (state == S_FILL)) &&
                     (beat_cnt != BEATS_ALL);

  assign fill_last = (state == S_FILL) &&
                     ((beat_cnt == BEATS_ALL) || (beat_take && (beat_cnt == BEATS_LAST)));

  assign word_write = req_wr && (((state == S_COMPARE) && hit) || (state == S_DONE));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req_ok) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (hit)               state_nxt = S_IDLE;
        else if (victim_dirty) state_nxt = S_WB;
        else                   state_nxt = S_ALLOC;
      end
      S_WB: begin
        if (!mem_busy && (wb_cnt == '1)) state_nxt = S_ALLOC;
      end
      S_ALLOC: begin
        if (!mem_busy && (rd_cnt == '1)) state_nxt = S_FILL;
      end
      S_FILL: begin
        if (fill_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from state so that reset clears them immediately.
  always_comb begin
    Done      = 1'b0;
    CacheHit  = 1'b0;
    Stall     = 1'b0;
    DataOut   = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 16'h0000;
    unique case (state)
      S_IDLE: begin
      end
      S_COMPARE: begin
        if (hit) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          if (!req_wr) DataOut = rd_word;
        end else begin
          Stall = 1'b1;
        end
      end
      S_WB: begin
        Stall     = 1'b1;
        mem_wr    = !mem_busy;
        mem_addr  = {tag_arr[req_idx], req_idx, wb_cnt, 1'b0};
        mem_wdata = data_arr[{req_idx, wb_cnt}];
      end
      S_ALLOC: begin
        Stall    = 1'b1;
        mem_rd   = !mem_busy;
        mem_addr = {req_tag, req_idx, rd_cnt, 1'b0};
      end
      S_FILL: begin
        Stall = 1'b1;
      end
      S_DONE: begin
        Stall = 1'b1;
        Done  = 1'b1;
        if (!req_wr) DataOut = rd_word;
      end
      default: begin
      end
    endcase
  end

  assign err = err_q;

  // Control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      req_tag  <= '0;
      req_idx  <= '0;
      req_word <= '0;
      req_data <= 16'h0000;
      req_wr   <= 1'b0;
      wb_cnt   <= '0;
      rd_cnt   <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= (state == S_IDLE) && req_bad;

      if ((state == S_IDLE) && req_ok) begin
        req_tag  <= in_tag;
        req_idx  <= in_idx;
        req_word <= in_word;
        req_data <= DataIn;
        req_wr   <= Wr;
      end

      if (state == S_COMPARE) begin
        wb_cnt   <= '0;
        rd_cnt   <= '0;
        beat_cnt <= '0;
      end
      if (mem_wr)    wb_cnt   <= wb_cnt + 1'b1;
      if (mem_rd)    rd_cnt   <= rd_cnt + 1'b1;
      if (beat_take) beat_cnt <= beat_cnt + 1'b1;

      if (fill_last) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (word_write) dirty_q[req_idx] <= 1'b1;
    end
  end

  // Array writes: refill beats, the tag on the final beat, and op merges.
  always_ff @(posedge clk) begin
    if (beat_take) data_arr[{req_idx, beat_cnt[OFFSET_W-1:0]}] <= mem_rdata;
    if (word_write) data_arr[{req_idx, req_word}] <= req_data;
    if (fill_last) tag_arr[req_idx] <= req_tag;
  end

`ifdef MEM_SYSTEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else if (Done) begin
      if (CacheHit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'h0001;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_system_param.sv
// tb/tb_mem_system_param.sv - randomized scoreboard bench for mem_system_param

module tb_mem_system_param;

  localparam bit MEM_TYPE = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_busy = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_rvalid = 1'b0;
`ifdef MEM_SYSTEM_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  mem_system_param #(
    .ADDR_W(16), .INDEX_W(8), .OFFSET_W(2), .MEM_TYPE(MEM_TYPE)
  ) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
`ifdef MEM_SYSTEM_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Reference model: cache lines as plain arrays plus a reference memory image.
  bit          mv [256];
  bit          md [256];
  logic [4:0]  mt [256];
  logic [15:0] ml [256][4];
  logic [15:0] ref_mem [32768];
  logic [15:0] sim_mem [32768];

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 error
    bit          hit;
    logic [15:0] data;
    int          cyc;
    int          lat;    // -1: latency not checked
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] exp_rd_q [$];
  logic [15:0] exp_wa_q [$];
  logic [15:0] exp_wd_q [$];

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  // Memory side
  typedef struct {
    logic [15:0] d;
    int          due;
  } beat_t;

  beat_t pipe [$];
  bit    rand_busy = 1'b0;
  bit    rand_lat  = 1'b0;
  bit    busy_trig = 1'b0;
  int    busy_left = 0;
  int    rd_accepts = 0;
  int    last_due = 0;
  int    last_lat = 0;

  always @(negedge clk) begin
    bit forced;
    int due;
    if (!rst) begin
      pipe.delete();
      mem_busy   = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      busy_left  = 0;
      last_due   = 0;
    end else begin
      forced = 1'b0;
      if (busy_left > 0) begin
        mem_busy = 1'b1;
        busy_left--;
        forced = 1'b1;
      end else begin
        mem_busy = rand_busy && ($urandom_range(0, 3) == 0);
      end
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pipe[0].d;
        pipe.delete(0);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
      end
      #1;
      if (mem_rd && mem_wr) bad("mem_rd_and_wr", {mem_rd, mem_wr});
      if (forced) begin
        chk("busy_rd_low", 32'(mem_rd), 32'd0);
        if (exp_rd_q.size() > 0) chk("busy_addr_hold", 32'(mem_addr), 32'(exp_rd_q[0]));
      end
      if (mem_rd) begin
        if (exp_rd_q.size() == 0) bad("mem_rd_unexpected", 32'(mem_addr));
        else chk("mem_rd_addr", 32'(mem_addr), 32'(exp_rd_q.pop_front()));
        due = cyc + (rand_lat ? int'($urandom_range(1, 3)) : 2);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pipe.push_back('{sim_mem[mem_addr[15:1]], due});
        rd_accepts++;
        if (busy_trig) begin
          busy_trig = 1'b0;
          busy_left = 3;
        end
      end
      if (mem_wr) begin
        if (exp_wa_q.size() == 0) begin
          bad("mem_wr_unexpected", 32'(mem_addr));
        end else begin
          chk("mem_wr_addr", 32'(mem_addr), 32'(exp_wa_q.pop_front()));
          chk("mem_wr_data", 32'(mem_wdata), 32'(exp_wd_q.pop_front()));
        end
        sim_mem[mem_addr[15:1]] = mem_wdata;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      if (Done && err) bad("done_with_err", {Done, err});
      if (Done || err) begin
        if (exp_q.size() == 0) begin
          bad("response_unexpected", {Done, err});
        end else begin
          e = exp_q.pop_front();
          last_lat = cyc - e.cyc;
          chk("resp_is_err", 32'(err), 32'(e.kind == 2));
          if (e.lat >= 0) chk("latency", 32'(last_lat), 32'(e.lat));
          if (err) begin
            chk("stall_at_err", 32'(Stall), 32'd0);
          end else begin
            chk("cache_hit", 32'(CacheHit), 32'(e.hit));
            chk("stall_at_done", 32'(Stall), 32'(!e.hit));
            if (e.kind == 0) chk("dataout", 32'(DataOut), 32'(e.data));
          end
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ctrl"}, {26'd0, Done, Stall, CacheHit, err, mem_rd, mem_wr}, 32'd0);
    chk({tag, "_data"}, {DataOut, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    #2;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      bad("response_timeout", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input int miss_lat, input bit wait_done);
    exp_t        e;
    logic [7:0]  idx;
    logic [4:0]  tg;
    logic [1:0]  w;
    @(negedge clk);
    if (rd || wr) begin
      if ((rd && wr) || a[0] || (wr && !MEM_TYPE)) begin
        e = '{2, 1'b0, 16'h0000, cyc, 1};
      end else begin
        idx = a[10:3];
        tg  = a[15:11];
        w   = a[2:1];
        e.kind = wr ? 1 : 0;
        e.cyc  = cyc;
        e.hit  = mv[idx] && (mt[idx] == tg);
        e.lat  = e.hit ? 1 : miss_lat;
        if (!e.hit) begin
          if (mv[idx] && md[idx]) begin
            for (int k = 0; k < 4; k++) begin
              exp_wa_q.push_back({mt[idx], idx, 2'(k), 1'b0});
              exp_wd_q.push_back(ml[idx][k]);
              ref_mem[{mt[idx], idx, 2'(k)}] = ml[idx][k];
            end
          end
          for (int k = 0; k < 4; k++) begin
            exp_rd_q.push_back({tg, idx, 2'(k), 1'b0});
            ml[idx][k] = ref_mem[{tg, idx, 2'(k)}];
          end
          mv[idx] = 1'b1;
          md[idx] = 1'b0;
          mt[idx] = tg;
        end
        if (wr) begin
          ml[idx][w] = d;
          md[idx] = 1'b1;
          e.data = 16'h0000;
        end else begin
          e.data = ml[idx][w];
        end
      end
      exp_q.push_back(e);
    end
    Rd = rd;
    Wr = wr;
    Addr = a;
    DataIn = d;
    @(negedge clk);
    Rd = 1'b0;
    Wr = 1'b0;
    if (wait_done) drain();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l0;
    int start;
    int mism;
    logic [4:0] tg;
    logic [7:0] idx;
    logic [1:0] w;
    logic [15:0] a;
    bit rd;
    int r;

    rst = 1'b0;
    Rd = 1'b0;
    Wr = 1'b0;
    Addr = 16'h0000;
    DataIn = 16'h0000;
    for (int i = 0; i < 32768; i++) begin
      sim_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
      ref_mem[i] = sim_mem[i];
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Cold miss, then write/read hits, then dirty eviction of the same index
    req(1'b1, 1'b0, 16'h0010, 16'h0000, -1, 1'b1);
    req(1'b0, 1'b1, 16'h0012, 16'hBEEF, -1, 1'b1);
    req(1'b1, 1'b0, 16'h0012, 16'h0000, -1, 1'b1);
    req(1'b1, 1'b0, 16'h0810, 16'h0000, -1, 1'b1);
    chk("wb_word1", 32'(sim_mem[9]), 32'h0000BEEF);

    // Malformed requests
    req(1'b1, 1'b1, 16'h0020, 16'h1234, -1, 1'b1);
    req(1'b1, 1'b0, 16'h0013, 16'h0000, -1, 1'b1);

    // Busy during ALLOC stretches the miss by exactly the busy cycles
    req(1'b1, 1'b0, 16'h0200, 16'h0000, -1, 1'b1);
    l0 = last_lat;
    busy_trig = 1'b1;
    req(1'b1, 1'b0, 16'h0208, 16'h0000, l0 + 3, 1'b1);

    // Reset while the refill is outstanding
    start = rd_accepts;
    req(1'b1, 1'b0, 16'h0280, 16'h0000, -1, 1'b0);
    for (int n = 0; n < 100 && (rd_accepts - start) < 4; n++) begin
      @(negedge clk);
      #3;
    end
    chk("reads_before_reset", 32'(rd_accepts - start), 32'd4);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero_outputs("midfill_reset");
    model_reset();
    exp_q.delete();
    exp_rd_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req(1'b1, 1'b0, 16'h0280, 16'h0000, -1, 1'b1);

    // Randomized traffic over a few conflicting lines
    rand_busy = 1'b1;
    rand_lat = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tg = 5'($urandom_range(0, 3));
      idx = 8'($urandom_range(0, 3));
      w = 2'($urandom_range(0, 3));
      a = {tg, idx, w, 1'b0};
      r = $urandom_range(0, 9);
      if (r == 0) begin
        req(1'b1, 1'b1, a, 16'($urandom), -1, 1'b1);
      end else if (r == 1) begin
        req(1'b1, 1'b0, a | 16'h0001, 16'h0000, -1, 1'b1);
      end else begin
        rd = 1'($urandom_range(0, 1));
        req(rd, !rd, a, 16'($urandom), -1, 1'b1);
      end
    end
    repeat (10) @(negedge clk);

    chk("exp_rd_left", 32'(exp_rd_q.size()), 32'd0);
    chk("exp_wr_left", 32'(exp_wa_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < 32768; i++) if (sim_mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
